decode_cycle: RTL and testbench
===============================

# decode_cycle

Second stage of the five-stage pipelined RISC-V core. It takes the IF/ID outputs of the fetch stage (InstrD, PCD, PCPlus4D) and decodes the instruction. It owns the 32×32 register file, which the writeback stage writes, and it generates main/ALU control and the sign-extended immediate. All results are registered into the ID/EX pipeline register for the execute stage.

## Interface
- No parameters; XLEN fixed at 32, register file fixed at 32 entries.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from fetch stage
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback register-file write enable
- RDW  in  5  writeback destination register
- ResultW  in  32  writeback data
- FlushE  in  1  squash the instruction entering EX (taken branch)
- RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, BranchE  out  1 each  registered control
- ALUControlE  out  3  registered ALU operation
- RD1_E, RD2_E  out  32  registered rs1/rs2 read data
- Imm_Ext_E  out  32  registered sign-extended immediate
- RS1_E, RS2_E, RD_E  out  5  registered register indices
- PCE, PCPlus4E  out  32  registered PCD, PCPlus4D

## Operation
- **Field extraction:** rs1 = InstrD[19:15], rs2 = [24:20], rd = [11:7], funct3 = [14:12], funct7b5 = [30].
- **Supported opcodes:** lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011. Any other opcode decodes to NOP: all control bits 0, ALUControl 000.
- **Main decode:**
  - lw: RegWrite=1, ALUSrc=1, ResultSrc=1, immediate I.
  - sw: MemWrite=1, ALUSrc=1, immediate S.
  - R-type: RegWrite=1.
  - I-ALU: RegWrite=1, ALUSrc=1, immediate I.
  - beq: Branch=1, immediate B.
- **ALU decode:**
  - lw/sw → 000 (add); beq → 001 (sub).
  - R/I by funct3:
    - 000 → add (000). For R-type only, funct7b5=1 gives sub (001).
    - 111 → and 010; 110 → or 011; 010 → slt 101.
    - Any other funct3 → 000.
- **Immediates** (sign bit is InstrD[31]):
  - I = {20×[31], [31:20]}
  - S = {20×[31], [31:25], [11:7]}
  - B = {19×[31], [31], [7], [30:25], [11:8], 0}
  - Immediate is 0 for R-type and NOP.
- **Register file:**
  - Two combinational read ports; x0 always reads 0.
  - Write on rising edge when RegWriteW=1 and RDW≠0. Writes to x0 are dropped.
  - Same-cycle write-through: if RegWriteW=1, RDW≠0 and RDW equals a read index, that read port returns ResultW.
  - All 32 entries clear to 0 on reset.
- **ID/EX register:**
  - Captures all decoded values each rising edge.
  - FlushE=1 forces RegWriteE, MemWriteE, BranchE, ResultSrcE, ALUSrcE and ALUControlE to 0. Data, index and PC fields still load.
  - There is no stall input; the register loads every cycle.

## Timing
- Decode is one cycle: InstrD presented before edge N appears on the *E outputs after edge N.
- Register-file write and ID/EX capture happen on the same edge. With write-through, a value written at edge N appears in RD*_E for an instruction decoded in the cycle before edge N.
- **Reset:**
  - rst low immediately clears every output and every register-file entry, regardless of clk.
  - The first capture occurs on the first rising edge with rst high.
  - Reset asserted mid-stream discards the instruction in flight.
- **FlushE and RegWriteW together:** the register-file write still occurs; only the EX control is squashed.
- **RDW=0 with RegWriteW=1:** no state change and no write-through.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with InstrD=0x00500093 → all *E outputs 0. Release rst; after 1 edge → RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=0x00000005, RD_E=1, RS1_E=0.
- **Load/store:**
  - InstrD=0xFFC0A103 (lw x2,-4(x1)) → Imm_Ext_E=0xFFFFFFFC, ResultSrcE=1, RegWriteE=1, RD_E=2.
  - Next, 0x0020A423 (sw x2,8(x1)) → MemWriteE=1, RegWriteE=0, Imm_Ext_E=8, RS2_E=2.
- **Branch and flush:**
  - InstrD=0x00208863 (beq x1,x2,+16) → BranchE=1, ALUControlE=001, Imm_Ext_E=0x00000010.
  - Repeat with FlushE=1 → all control 0, PCE still equals PCD.
- **R-type decode:**
  - 0x40208233 (sub x4,x1,x2) → ALUControlE=001.
  - 0x0020F233 (and) → 010.
  - 0x0020A233 (slt) → 101.
  - Illegal opcode 0x0000007F → all control 0.
- **Write-through:**
  - RegWriteW=1, RDW=3, ResultW=0xDEADBEEF in the same cycle as InstrD=0x00018233 (add x4,x3,x0) → RD1_E=0xDEADBEEF after that edge.
  - The next cycle, re-decoding the same instruction still reads 0xDEADBEEF.
- **x0 protection:** RegWriteW=1, RDW=0, ResultW=0x12345678, then decode add x5,x0,x0 → RD1_E=RD2_E=0.

Source files
------------

// File: rtl/decode_cycle_if.sv
// IF/ID inputs, writeback port and ID/EX outputs of the decode stage, grouped as one bundle.
// The decode stage uses the slave modport; whatever drives fetch and writeback uses master.
interface decode_cycle_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        FlushE;

  logic        RegWriteE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        ResultSrcE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [4:0]  RS1_E;
  logic [4:0]  RS2_E;
  logic [4:0]  RD_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, BranchE, ALUControlE,
    input  RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, BranchE, ALUControlE,
    output RD1_E, RD2_E, Imm_Ext_E, RS1_E, RS2_E, RD_E, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle.sv
// Decode stage of the five-stage RISC-V pipeline: main/ALU decode, immediate generation,
// 32x32 register file with write-through, and the ID/EX pipeline register.
module decode_cycle (
  input  logic           clk,
  input  logic           rst,
  decode_cycle_if.slave  bus
);

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {ImmNone, ImmI, ImmS, ImmB} imm_sel_e;

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpIAlu = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7b5;

  assign opcode   = bus.InstrD[6:0];
  assign rs1      = bus.InstrD[19:15];
  assign rs2      = bus.InstrD[24:20];
  assign rd       = bus.InstrD[11:7];
  assign funct3   = bus.InstrD[14:12];
  assign funct7b5 = bus.InstrD[30];

  logic        reg_write, mem_write, alu_src, result_src, branch;
  logic        arith;
  alu_op_e     alu_op;
  imm_sel_e    imm_sel;
  logic [31:0] imm_ext;

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    result_src = 1'b0;
    branch     = 1'b0;
    arith      = 1'b0;
    alu_op     = AluAdd;
    imm_sel    = ImmNone;
    case (opcode)
      OpLw: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 1'b1;
        imm_sel    = ImmI;
      end
      OpSw: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        imm_sel   = ImmS;
      end
      OpR: begin
        reg_write = 1'b1;
        arith     = 1'b1;
      end
      OpIAlu: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        arith     = 1'b1;
        imm_sel   = ImmI;
      end
      OpBeq: begin
        branch  = 1'b1;
        alu_op  = AluSub;
        imm_sel = ImmB;
      end
      default: ;
    endcase

    if (arith) begin
      case (funct3)
        3'b000:  alu_op = (opcode == OpR && funct7b5) ? AluSub : AluAdd;
        3'b111:  alu_op = AluAnd;
        3'b110:  alu_op = AluOr;
        3'b010:  alu_op = AluSlt;
        default: alu_op = AluAdd;
      endcase
    end

    case (imm_sel)
      ImmI:    imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
      ImmS:    imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
      ImmB:    imm_ext = {{19{bus.InstrD[31]}}, bus.InstrD[31], bus.InstrD[7],
                          bus.InstrD[30:25], bus.InstrD[11:8], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Register file; entry 0 is never written so it stays zero from reset.
  logic [31:0] rf_q [32];
  logic        rf_we;

  assign rf_we = bus.RegWriteW && (bus.RDW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[bus.RDW] <= bus.ResultW;
    end
  end

  logic [31:0] rd1, rd2;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != 5'd0) rd1 = (rf_we && bus.RDW == rs1) ? bus.ResultW : rf_q[rs1];
    if (rs2 != 5'd0) rd2 = (rf_we && bus.RDW == rs2) ? bus.ResultW : rf_q[rs2];
  end

  // ID/EX register; a flush squashes only the control fields.
  logic [4:0]  ctrl_d, ctrl_q;
  logic [2:0]  alu_ctrl_d, alu_ctrl_q;
  logic [31:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;

  always_comb begin
    ctrl_d     = {reg_write, mem_write, alu_src, result_src, branch};
    alu_ctrl_d = alu_op;
    if (bus.FlushE) begin
      ctrl_d     = '0;
      alu_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      alu_ctrl_q <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      pc4_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_ctrl_d;
      rd1_q      <= rd1;
      rd2_q      <= rd2;
      imm_q      <= imm_ext;
      rs1_q      <= rs1;
      rs2_q      <= rs2;
      rd_q       <= rd;
      pc_q       <= bus.PCD;
      pc4_q      <= bus.PCPlus4D;
    end
  end

  assign {bus.RegWriteE, bus.MemWriteE, bus.ALUSrcE, bus.ResultSrcE, bus.BranchE} = ctrl_q;
  assign bus.ALUControlE = alu_ctrl_q;
  assign bus.RD1_E       = rd1_q;
  assign bus.RD2_E       = rd2_q;
  assign bus.Imm_Ext_E   = imm_q;
  assign bus.RS1_E       = rs1_q;
  assign bus.RS2_E       = rs2_q;
  assign bus.RD_E        = rd_q;
  assign bus.PCE         = pc_q;
  assign bus.PCPlus4E    = pc4_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized instructions and
// writebacks checked against an arithmetic reference model of decode and the register file.
module tb_decode_cycle;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  decode_cycle_if dif ();

  decode_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  logic [31:0] mrf [32];

  // Packed observation: {ctrl5, aluc3, rd1, rd2, imm, rs1, rs2, rd, pc, pc4} = 183 bits
  function automatic logic [182:0] observe();
    return {dif.RegWriteE, dif.MemWriteE, dif.ALUSrcE, dif.ResultSrcE, dif.BranchE,
            dif.ALUControlE, dif.RD1_E, dif.RD2_E, dif.Imm_Ext_E, dif.RS1_E, dif.RS2_E,
            dif.RD_E, dif.PCE, dif.PCPlus4E};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (dif.RegWriteW && dif.RDW == idx) return dif.ResultW;
    return mrf[idx];
  endfunction

  // Reference built from the instruction-set rules using integer arithmetic for immediates.
  function automatic logic [182:0] model_expect();
    logic [31:0] ins;
    int          si, imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        rw, mw, as, rs, br;
    logic [2:0]  alu;
    ins = dif.InstrD;
    si  = int'(ins);
    opc = ins[6:0];
    f3  = ins[14:12];
    {rw, mw, as, rs, br} = 5'b0;
    alu = 3'd0;
    imm = 0;
    if (opc == 7'h03) begin
      rw = 1; as = 1; rs = 1; imm = si >>> 20;
    end else if (opc == 7'h23) begin
      mw = 1; as = 1; imm = (si >>> 25) * 32 + int'(ins[11:7]);
    end else if (opc == 7'h63) begin
      br = 1; alu = 3'd1;
      imm = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
            + int'(ins[11:8]) * 2;
    end else if (opc == 7'h33 || opc == 7'h13) begin
      rw = 1;
      if (opc == 7'h13) begin
        as = 1; imm = si >>> 20;
      end
      if (f3 == 3'd0 && opc == 7'h33 && ins[30]) alu = 3'd1;
      else if (f3 == 3'd7) alu = 3'd2;
      else if (f3 == 3'd6) alu = 3'd3;
      else if (f3 == 3'd2) alu = 3'd5;
    end
    if (dif.FlushE) begin
      {rw, mw, as, rs, br} = 5'b0;
      alu = 3'd0;
    end
    return {rw, mw, as, rs, br, alu, model_read(ins[19:15]), model_read(ins[24:20]),
            32'(imm), ins[19:15], ins[24:20], ins[11:7], dif.PCD, dif.PCPlus4D};
  endfunction

  task automatic apply(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                       input logic we, input logic [4:0] rdw, input logic [31:0] resw);
    @(negedge clk);
    dif.InstrD    = instr;
    dif.PCD       = pc;
    dif.PCPlus4D  = pc + 32'd4;
    dif.FlushE    = flush;
    dif.RegWriteW = we;
    dif.RDW       = rdw;
    dif.ResultW   = resw;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [182:0] o;
    rst = 1'b0;
    dif.InstrD = 32'h00500093; dif.PCD = 32'h40; dif.PCPlus4D = 32'h44;
    dif.FlushE = 0; dif.RegWriteW = 0; dif.RDW = 0; dif.ResultW = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    o = observe();
    if (o !== '0) begin
      n_bad++; $display("FAIL reset_zero: got %h want 0", o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({dif.RegWriteE, dif.ALUSrcE, dif.ALUControlE, dif.Imm_Ext_E, dif.RD_E, dif.RS1_E}
        !== {1'b1, 1'b1, 3'd0, 32'h5, 5'd1, 5'd0}) begin
      n_bad++;
      $display("FAIL reset_first_capture: rw=%b as=%b aluc=%h imm=%h rd=%0d rs1=%0d",
               dif.RegWriteE, dif.ALUSrcE, dif.ALUControlE, dif.Imm_Ext_E, dif.RD_E,
               dif.RS1_E);
    end
  endtask

  task automatic test_load_store();
    apply(32'hFFC0A103, 32'h100, 0, 0, 0, 0);
    n_vec++;
    if ({dif.Imm_Ext_E, dif.ResultSrcE, dif.RegWriteE, dif.RD_E}
        !== {32'hFFFFFFFC, 1'b1, 1'b1, 5'd2}) begin
      n_bad++; $display("FAIL lw: imm=%h rsrc=%b rw=%b rd=%0d want fffffffc 1 1 2",
                        dif.Imm_Ext_E, dif.ResultSrcE, dif.RegWriteE, dif.RD_E);
    end
    apply(32'h0020A423, 32'h104, 0, 0, 0, 0);
    n_vec++;
    if ({dif.MemWriteE, dif.RegWriteE, dif.Imm_Ext_E, dif.RS2_E}
        !== {1'b1, 1'b0, 32'h8, 5'd2}) begin
      n_bad++; $display("FAIL sw: mw=%b rw=%b imm=%h rs2=%0d want 1 0 8 2",
                        dif.MemWriteE, dif.RegWriteE, dif.Imm_Ext_E, dif.RS2_E);
    end
  endtask

  task automatic test_branch_flush();
    apply(32'h00208863, 32'h200, 0, 0, 0, 0);
    n_vec++;
    if ({dif.BranchE, dif.ALUControlE, dif.Imm_Ext_E, dif.PCE}
        !== {1'b1, 3'd1, 32'h10, 32'h200}) begin
      n_bad++; $display("FAIL beq: br=%b aluc=%h imm=%h pc=%h want 1 1 10 200",
                        dif.BranchE, dif.ALUControlE, dif.Imm_Ext_E, dif.PCE);
    end
    apply(32'h00208863, 32'h204, 1, 0, 0, 0);
    n_vec++;
    if ({dif.RegWriteE, dif.MemWriteE, dif.ALUSrcE, dif.ResultSrcE, dif.BranchE,
         dif.ALUControlE, dif.PCE, dif.PCPlus4E, dif.Imm_Ext_E}
        !== {8'd0, 32'h204, 32'h208, 32'h10}) begin
      n_bad++; $display("FAIL flush: br=%b aluc=%h pc=%h pc4=%h imm=%h",
                        dif.BranchE, dif.ALUControlE, dif.PCE, dif.PCPlus4E, dif.Imm_Ext_E);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] ins [4];
    logic [3:0]  exp [4];
    ins[0] = 32'h40208233; exp[0] = {1'b1, 3'd1};
    ins[1] = 32'h0020F233; exp[1] = {1'b1, 3'd2};
    ins[2] = 32'h0020A233; exp[2] = {1'b1, 3'd5};
    ins[3] = 32'h0000007F; exp[3] = {1'b0, 3'd0};
    for (int i = 0; i < 4; i++) begin
      apply(ins[i], 32'h300 + 32'(i * 4), 0, 0, 0, 0);
      n_vec++;
      if ({dif.RegWriteE, dif.ALUControlE} !== exp[i] ||
          {dif.MemWriteE, dif.ALUSrcE, dif.ResultSrcE, dif.BranchE} !== 4'd0) begin
        n_bad++; $display("FAIL rtype[%0d] instr=%h: rw=%b aluc=%h other=%b%b%b%b want %h",
                          i, ins[i], dif.RegWriteE, dif.ALUControlE, dif.MemWriteE,
                          dif.ALUSrcE, dif.ResultSrcE, dif.BranchE, exp[i]);
      end
    end
  endtask

  task automatic test_write_through();
    apply(32'h00018233, 32'h400, 0, 1, 5'd3, 32'hDEADBEEF);
    n_vec++;
    if (dif.RD1_E !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL wt_same_cycle: rd1=%h want deadbeef", dif.RD1_E);
    end
    apply(32'h00018233, 32'h404, 0, 0, 0, 0);
    n_vec++;
    if (dif.RD1_E !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL wt_stored: rd1=%h want deadbeef", dif.RD1_E);
    end
  endtask

  task automatic test_x0_and_flush_write();
    apply(32'h000002B3, 32'h500, 0, 1, 5'd0, 32'h12345678);
    n_vec++;
    if ({dif.RD1_E, dif.RD2_E} !== 64'd0) begin
      n_bad++; $display("FAIL x0_wt: rd1=%h rd2=%h want 0 0", dif.RD1_E, dif.RD2_E);
    end
    apply(32'h000002B3, 32'h504, 1, 1, 5'd6, 32'hCAFEF00D);
    n_vec++;
    if ({dif.RD1_E, dif.RD2_E} !== 64'd0) begin
      n_bad++; $display("FAIL x0_stored: rd1=%h rd2=%h want 0 0", dif.RD1_E, dif.RD2_E);
    end
    apply(32'h000303B3, 32'h508, 0, 0, 0, 0);
    n_vec++;
    if (dif.RD1_E !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL flush_keeps_write: rd1=%h want cafef00d", dif.RD1_E);
    end
  endtask

  task automatic test_midstream_reset();
    logic [182:0] o;
    apply(32'h00208863, 32'h600, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    o = observe();
    if (o !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h want 0", o);
    end
    @(negedge clk);
    rst = 1'b1;
    apply(32'h00018233, 32'h700, 0, 0, 0, 0);
    n_vec++;
    if ({dif.RD1_E, dif.PCE} !== {32'd0, 32'h700}) begin
      n_bad++; $display("FAIL reset_clears_rf: rd1=%h pc=%h want 0 700", dif.RD1_E, dif.PCE);
    end
  endtask

  task automatic test_random();
    logic [6:0]   opcs [6];
    logic [182:0] exp, o;
    opcs[0] = 7'h03; opcs[1] = 7'h23; opcs[2] = 7'h33;
    opcs[3] = 7'h13; opcs[4] = 7'h63; opcs[5] = 7'h00;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      dif.InstrD = $urandom;
      dif.InstrD[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 4)];
      dif.InstrD[19:15] = 5'($urandom_range(0, 7));
      dif.InstrD[24:20] = 5'($urandom_range(0, 7));
      dif.PCD       = $urandom & 32'hFFFFFFFC;
      dif.PCPlus4D  = dif.PCD + 32'd4;
      dif.FlushE    = ($urandom_range(0, 4) == 0);
      dif.RegWriteW = ($urandom_range(0, 2) != 0);
      dif.RDW       = 5'($urandom_range(0, 7));
      dif.ResultW   = $urandom;
      exp = model_expect();
      @(posedge clk);
      if (dif.RegWriteW && dif.RDW != 0) mrf[dif.RDW] = dif.ResultW;
      #1;
      o = observe();
      n_vec++;
      if (o !== exp) begin
        n_bad++;
        $display("FAIL random[%0d] instr=%h: got %h want %h", n, dif.InstrD, o, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_branch_flush();
    test_rtype();
    test_write_through();
    test_x0_and_flush_write();
    test_midstream_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
